// File: rtl/complex_pipe_core.sv
// complex_pipe_core: three-stage complex-arithmetic pipeline over a
// register file of 2**AW packed {re, im} entries.
//   S1: accepted instruction (op, a1, a2, a3, imm)
//   S2: resolved operands (forwarded from S2 ALU, S3 data, or register file)
//   S3: reduced ALU result, written to the register file on the next free edge
// Handshake: an instruction transfers on a rising edge where
// in_valid & in_ready; in_ready is simply ~stall, and stall freezes every
// stage, the register-file write and the retired counter.
module complex_pipe_core #(
  parameter int DW  = 8,
  parameter int AW  = 5,
  parameter int SAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [AW-1:0]   in_a1,
  input  logic [AW-1:0]   in_a2,
  input  logic [AW-1:0]   in_a3,
  input  logic [2*DW-1:0] in_imm,
  input  logic            stall,
  output logic            wb_valid,
  output logic [AW-1:0]   wb_addr,
  output logic [2*DW-1:0] wb_data,
  output logic [31:0]     retired,
  input  logic [AW-1:0]   dbg_addr,
  output logic [2*DW-1:0] dbg_data
);

  localparam int CW    = 2 * DW;
  localparam int WW    = 2 * DW + 2;  // holds ac - bd without overflow
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic signed [WW-1:0] MAX_V = WW'((1 << (DW - 1)) - 1);
  localparam logic signed [WW-1:0] MIN_V = ~MAX_V;

  // Pipeline state
  logic          s1_valid_q, s1_valid_d;
  logic [1:0]    s1_op_q, s1_op_d;
  logic [AW-1:0] s1_a1_q, s1_a1_d, s1_a2_q, s1_a2_d, s1_a3_q, s1_a3_d;
  logic [CW-1:0] s1_imm_q, s1_imm_d;

  logic          s2_valid_q, s2_valid_d;
  logic [1:0]    s2_op_q, s2_op_d;
  logic [AW-1:0] s2_a3_q, s2_a3_d;
  logic [CW-1:0] s2_imm_q, s2_imm_d;
  logic [CW-1:0] s2_x_q, s2_x_d, s2_y_q, s2_y_d;

  logic          s3_valid_q, s3_valid_d;
  logic [AW-1:0] s3_a3_q, s3_a3_d;
  logic [CW-1:0] s3_data_q, s3_data_d;

  logic [31:0]   retired_q, retired_d;
  logic [CW-1:0] rf_q [DEPTH];
  logic [CW-1:0] rf_d [DEPTH];

  logic          rf_we;
  logic [CW-1:0] alu_data;
  logic [CW-1:0] opnd_x, opnd_y;

  // Narrow a full-width result to DW bits: wrap or clamp.
  function automatic logic [DW-1:0] reduce(input logic signed [WW-1:0] v);
    logic signed [WW-1:0] c;
    c = v;
    if (SAT != 0) begin
      if (v > MAX_V) c = MAX_V;
      else if (v < MIN_V) c = MIN_V;
    end
    return c[DW-1:0];
  endfunction

  // ALU on S2 operands: componentwise add/sub, full complex multiply, load.
  always_comb begin
    logic signed [DW-1:0] xr, xi, yr, yi;
    logic signed [WW-1:0] exr, exi, eyr, eyi, res_re, res_im;
    xr  = $signed(s2_x_q[CW-1:DW]);
    xi  = $signed(s2_x_q[DW-1:0]);
    yr  = $signed(s2_y_q[CW-1:DW]);
    yi  = $signed(s2_y_q[DW-1:0]);
    exr = xr;
    exi = xi;
    eyr = yr;
    eyi = yi;
    res_re = '0;
    res_im = '0;
    case (s2_op_q)
      OP_ADD: begin
        res_re = exr + eyr;
        res_im = exi + eyi;
      end
      OP_SUB: begin
        res_re = exr - eyr;
        res_im = exi - eyi;
      end
      OP_MUL: begin
        res_re = exr * eyr - exi * eyi;
        res_im = exr * eyi + exi * eyr;
      end
      default: begin
        res_re = '0;
        res_im = '0;
      end
    endcase
    if (s2_op_q == OP_LOAD) alu_data = s2_imm_q;
    else                    alu_data = {reduce(res_re), reduce(res_im)};
  end

  // Operand fetch for S1 with forwarding: S2 result, then S3 data, then RF.
  always_comb begin
    if (s2_valid_q && s2_a3_q == s1_a1_q)      opnd_x = alu_data;
    else if (s3_valid_q && s3_a3_q == s1_a1_q) opnd_x = s3_data_q;
    else                                       opnd_x = rf_q[s1_a1_q];
    if (s2_valid_q && s2_a3_q == s1_a2_q)      opnd_y = alu_data;
    else if (s3_valid_q && s3_a3_q == s1_a2_q) opnd_y = s3_data_q;
    else                                       opnd_y = rf_q[s1_a2_q];
  end

  // Next-state for all stages, register file and retired counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a1_d    = s1_a1_q;
    s1_a2_d    = s1_a2_q;
    s1_a3_d    = s1_a3_q;
    s1_imm_d   = s1_imm_q;
    s2_valid_d = s2_valid_q;
    s2_op_d    = s2_op_q;
    s2_a3_d    = s2_a3_q;
    s2_imm_d   = s2_imm_q;
    s2_x_d     = s2_x_q;
    s2_y_d     = s2_y_q;
    s3_valid_d = s3_valid_q;
    s3_a3_d    = s3_a3_q;
    s3_data_d  = s3_data_q;
    retired_d  = retired_q;
    rf_d       = rf_q;
    rf_we      = s3_valid_q && !stall;
    if (!stall) begin
      s1_valid_d = in_valid;
      s1_op_d    = in_op;
      s1_a1_d    = in_a1;
      s1_a2_d    = in_a2;
      s1_a3_d    = in_a3;
      s1_imm_d   = in_imm;
      s2_valid_d = s1_valid_q;
      s2_op_d    = s1_op_q;
      s2_a3_d    = s1_a3_q;
      s2_imm_d   = s1_imm_q;
      s2_x_d     = opnd_x;
      s2_y_d     = opnd_y;
      s3_valid_d = s2_valid_q;
      s3_a3_d    = s2_a3_q;
      s3_data_d  = alu_data;
    end
    if (rf_we) begin
      rf_d[s3_a3_q] = s3_data_q;
      retired_d     = retired_q + 32'd1;
    end
  end

  // State registers; reset clears valids, register file and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a1_q    <= '0;
      s1_a2_q    <= '0;
      s1_a3_q    <= '0;
      s1_imm_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_op_q    <= '0;
      s2_a3_q    <= '0;
      s2_imm_q   <= '0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      s3_valid_q <= 1'b0;
      s3_a3_q    <= '0;
      s3_data_q  <= '0;
      retired_q  <= '0;
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a1_q    <= s1_a1_d;
      s1_a2_q    <= s1_a2_d;
      s1_a3_q    <= s1_a3_d;
      s1_imm_q   <= s1_imm_d;
      s2_valid_q <= s2_valid_d;
      s2_op_q    <= s2_op_d;
      s2_a3_q    <= s2_a3_d;
      s2_imm_q   <= s2_imm_d;
      s2_x_q     <= s2_x_d;
      s2_y_q     <= s2_y_d;
      s3_valid_q <= s3_valid_d;
      s3_a3_q    <= s3_a3_d;
      s3_data_q  <= s3_data_d;
      retired_q  <= retired_d;
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign in_ready = ~stall;
  assign wb_valid = s3_valid_q & ~stall;
  assign wb_addr  = s3_a3_q;
  assign wb_data  = s3_data_q;
  assign retired  = retired_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_complex_pipe_core.sv
// Bench for complex_pipe_core: two instances (wrap and saturate) share
// stimulus; an in-order architectural model predicts each writeback.
module tb_complex_pipe_core;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int CW = 2 * DW;
  localparam int NR = 1 << AW;
  localparam int NV = 11;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, LOAD = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [1:0]    in_op = '0;
  logic [AW-1:0] in_a1 = '0, in_a2 = '0, in_a3 = '0;
  logic [CW-1:0] in_imm = '0;
  logic          stall = 1'b0;
  logic [AW-1:0] dbg_addr = '0;

  logic          in_ready0, in_ready1, wb_valid0, wb_valid1;
  logic [AW-1:0] wb_addr0, wb_addr1;
  logic [CW-1:0] wb_data0, wb_data1, dbg_data0, dbg_data1;
  logic [31:0]   retired0, retired1;

  complex_pipe_core #(.DW(DW), .AW(AW), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3),
    .in_imm(in_imm), .stall(stall), .wb_valid(wb_valid0),
    .wb_addr(wb_addr0), .wb_data(wb_data0), .retired(retired0),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data0)
  );

  complex_pipe_core #(.DW(DW), .AW(AW), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3),
    .in_imm(in_imm), .stall(stall), .wb_valid(wb_valid1),
    .wb_addr(wb_addr1), .wb_data(wb_data1), .retired(retired1),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data1)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [AW+CW-1:0] exp_q0[$];
  logic [AW+CW-1:0] exp_q1[$];
  logic [CW-1:0]    model_rf [2][NR];

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] a1, a2, a3;
    logic [CW-1:0] imm;
    logic [CW-1:0] e0, e1;
  } vec_t;
  vec_t tab [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain integers, then wrap or clamp to DW bits.
  function automatic logic [DW-1:0] red(input int v, input bit sat);
    logic [31:0] u;
    int lim;
    lim = (1 << (DW - 1)) - 1;
    if (sat) begin
      if (v > lim) v = lim;
      if (v < -lim - 1) v = -lim - 1;
    end
    u = v;
    return u[DW-1:0];
  endfunction

  function automatic logic [CW-1:0] ref_exec(input int s, input logic [1:0] op,
      input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [CW-1:0] imm);
    logic [CW-1:0] x, y;
    int xr, xi, yr, yi, rr, ri;
    x  = model_rf[s][a1];
    y  = model_rf[s][a2];
    xr = int'($signed(x[CW-1:DW]));
    xi = int'($signed(x[DW-1:0]));
    yr = int'($signed(y[CW-1:DW]));
    yi = int'($signed(y[DW-1:0]));
    rr = 0;
    ri = 0;
    case (op)
      ADD: begin rr = xr + yr; ri = xi + yi; end
      SUB: begin rr = xr - yr; ri = xi - yi; end
      MUL: begin rr = xr * yr - xi * yi; ri = xr * yi + xi * yr; end
      default: return imm;
    endcase
    return {red(rr, s != 0), red(ri, s != 0)};
  endfunction

  // Writeback monitor: every wb_valid must match the oldest expectation.
  always @(negedge clk) begin
    logic [AW+CW-1:0] e;
    if (!rst) begin
      if (wb_valid0) begin
        if (exp_q0.size() == 0) chk("wb0_spurious", 32'd1, 32'd0);
        else begin
          e = exp_q0.pop_front();
          chk("wb0_addr", 32'(wb_addr0), 32'(e[AW+CW-1:CW]));
          chk("wb0_data", 32'(wb_data0), 32'(e[CW-1:0]));
        end
      end
      if (wb_valid1) begin
        if (exp_q1.size() == 0) chk("wb1_spurious", 32'd1, 32'd0);
        else begin
          e = exp_q1.pop_front();
          chk("wb1_addr", 32'(wb_addr1), 32'(e[AW+CW-1:CW]));
          chk("wb1_data", 32'(wb_data1), 32'(e[CW-1:0]));
        end
      end
    end
  end

  // Driver: present one cycle of inputs; an accepted instruction updates
  // the model and queues its writeback (table values override when given).
  task automatic step(input bit v, input logic [1:0] op, input logic [AW-1:0] a1,
      input logic [AW-1:0] a2, input logic [AW-1:0] a3, input logic [CW-1:0] imm,
      input bit st, input bit use_tab, input logic [CW-1:0] t0, input logic [CW-1:0] t1);
    logic [CW-1:0] d0, d1;
    in_valid = v;
    in_op    = op;
    in_a1    = a1;
    in_a2    = a2;
    in_a3    = a3;
    in_imm   = imm;
    stall    = st;
    if (v && !st) begin
      d0 = ref_exec(0, op, a1, a2, imm);
      d1 = ref_exec(1, op, a1, a2, imm);
      model_rf[0][a3] = d0;
      model_rf[1][a3] = d1;
      if (use_tab) begin
        d0 = t0;
        d1 = t1;
      end
      exp_q0.push_back({a3, d0});
      exp_q1.push_back({a3, d1});
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, ADD, '0, '0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    stall    = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    n_acc = 0;
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < NR; r++) model_rf[s][r] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic expect_wb(input string name, input bit v);
    @(negedge clk);
    #1;
    chk({name, "_wb0"}, 32'(wb_valid0), 32'(v));
    chk({name, "_wb1"}, 32'(wb_valid1), 32'(v));
  endtask

  task automatic chk_reg(input string name, input logic [AW-1:0] a,
      input logic [CW-1:0] e0, input logic [CW-1:0] e1);
    dbg_addr = a;
    #1;
    chk({name, "_r0"}, 32'(dbg_data0), 32'(e0));
    chk({name, "_r1"}, 32'(dbg_data1), 32'(e1));
  endtask

  task automatic chk_drain(input string name);
    chk({name, "_ret0"}, retired0, 32'(n_acc));
    chk({name, "_ret1"}, retired1, 32'(n_acc));
    chk({name, "_left0"}, 32'(exp_q0.size()), 32'd0);
    chk({name, "_left1"}, 32'(exp_q1.size()), 32'd0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ret_hold;
    // Directed vectors, two instructions per line of intent.
    tab[0]  = '{LOAD, 5'd0, 5'd0, 5'd1,  16'h0304, 16'h0304, 16'h0304};
    tab[1]  = '{LOAD, 5'd0, 5'd0, 5'd2,  16'h01FE, 16'h01FE, 16'h01FE};
    tab[2]  = '{ADD,  5'd1, 5'd2, 5'd3,  16'h0000, 16'h0402, 16'h0402};
    tab[3]  = '{MUL,  5'd1, 5'd2, 5'd4,  16'h0000, 16'h0BFE, 16'h0BFE};
    tab[4]  = '{SUB,  5'd4, 5'd1, 5'd5,  16'h0000, 16'h08FA, 16'h08FA};
    tab[5]  = '{LOAD, 5'd3, 5'd4, 5'd7,  16'h649C, 16'h649C, 16'h649C};
    tab[6]  = '{ADD,  5'd7, 5'd7, 5'd6,  16'h0000, 16'hC838, 16'h7F80};
    tab[7]  = '{MUL,  5'd7, 5'd7, 5'd8,  16'h0000, 16'h00E0, 16'h0080};
    tab[8]  = '{SUB,  5'd2, 5'd7, 5'd9,  16'h0000, 16'h9D62, 16'h9D62};
    tab[9]  = '{MUL,  5'd3, 5'd3, 5'd10, 16'h0000, 16'h0C10, 16'h0C10};
    tab[10] = '{SUB,  5'd6, 5'd1, 5'd11, 16'h0000, 16'hC534, 16'h7C80};

    // Reset state
    do_reset();
    chk("rst_ret0", retired0, 32'd0);
    chk("rst_ret1", retired1, 32'd0);
    chk("rst_wbv0", 32'(wb_valid0), 32'd0);
    chk("rst_wbd0", 32'(wb_data0), 32'd0);
    chk("rst_wba0", 32'(wb_addr0), 32'd0);
    chk_reg("rst_a0", 5'd0, '0, '0);
    chk_reg("rst_a7", 5'd7, '0, '0);
    chk_reg("rst_a31", 5'd31, '0, '0);

    // Latency: accepted at edge k -> wb during k+2..k+3, RF at k+3
    step(1, LOAD, 5'd0, 5'd0, 5'd1, 16'h0304, 0, 1, 16'h0304, 16'h0304);
    expect_wb("lat_k", 0);
    idle(1);
    expect_wb("lat_k1", 0);
    chk_reg("lat_norf", 5'd1, 16'h0000, 16'h0000);
    idle(1);
    expect_wb("lat_k2", 1);
    idle(1);
    expect_wb("lat_k3", 0);
    chk_reg("lat_rf", 5'd1, 16'h0304, 16'h0304);

    // Table: back-to-back dependent instructions
    do_reset();
    for (int i = 0; i < NV; i++)
      step(1, tab[i].op, tab[i].a1, tab[i].a2, tab[i].a3, tab[i].imm, 0, 1, tab[i].e0, tab[i].e1);
    idle(4);
    chk_drain("tab");
    chk_reg("tab_r3", 5'd3, 16'h0402, 16'h0402);
    chk_reg("tab_r6", 5'd6, 16'hC838, 16'h7F80);
    chk_reg("tab_r11", 5'd11, 16'hC534, 16'h7C80);

    // Stall between dependent instructions while S3 holds a valid result
    do_reset();
    step(1, LOAD, 5'd0, 5'd0, 5'd1, 16'h0304, 0, 1, 16'h0304, 16'h0304);
    step(1, LOAD, 5'd0, 5'd0, 5'd2, 16'h01FE, 0, 1, 16'h01FE, 16'h01FE);
    step(1, LOAD, 5'd0, 5'd0, 5'd9, 16'h1111, 0, 1, 16'h1111, 16'h1111);
    ret_hold = retired0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_op    = ADD;
      in_a1    = 5'd1;
      in_a2    = 5'd2;
      in_a3    = 5'd12;
      stall    = 1'b1;
      @(negedge clk);
      #1;
      chk("stall_rdy0", 32'(in_ready0), 32'd0);
      chk("stall_rdy1", 32'(in_ready1), 32'd0);
      chk("stall_wbv", 32'(wb_valid0 | wb_valid1), 32'd0);
      chk("stall_ret", retired0, ret_hold);
      @(posedge clk);
      #1;
    end
    chk("stall_ret_end", retired0, ret_hold);
    chk_reg("stall_r12", 5'd12, 16'h0000, 16'h0000);
    step(1, ADD, 5'd1, 5'd2, 5'd3, '0, 0, 1, 16'h0402, 16'h0402);
    step(1, MUL, 5'd3, 5'd1, 5'd4, '0, 0, 1, 16'h0416, 16'h0416);
    idle(4);
    chk_drain("stall");
    chk_reg("stall_r3", 5'd3, 16'h0402, 16'h0402);
    chk_reg("stall_r4", 5'd4, 16'h0416, 16'h0416);

    // Reset with three instructions in flight: nothing may write back
    step(1, LOAD, 5'd0, 5'd0, 5'd20, 16'h5555, 0, 0, '0, '0);
    step(1, ADD,  5'd20, 5'd3, 5'd21, '0, 0, 0, '0, '0);
    step(1, MUL,  5'd21, 5'd4, 5'd22, '0, 0, 0, '0, '0);
    do_reset();
    idle(6);
    chk("mid_ret0", retired0, 32'd0);
    chk("mid_ret1", retired1, 32'd0);
    for (int r = 0; r < NR; r++) chk_reg("mid_rf", r[AW-1:0], '0, '0);

    // Random traffic against the architectural model
    for (int i = 0; i < 600; i++) begin
      logic [1:0] op;
      logic [AW-1:0] a1, a2, a3;
      bit v, st;
      op = 2'($urandom_range(0, 3));
      a1 = 5'($urandom_range(0, 7));
      a2 = 5'($urandom_range(0, 7));
      a3 = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      v  = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 9) < 2);
      step(v, op, a1, a2, a3, 16'($urandom), st, 0, '0, '0);
    end
    idle(5);
    chk_drain("rand");
    for (int r = 0; r < NR; r++)
      chk_reg("rand_rf", r[AW-1:0], model_rf[0][r], model_rf[1][r]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/complex_pipe_core.md
COMPLEX_PIPE_CORE -- requirements
Module: complex_pipe_core

Interface
REQ-001 Parameter DW, default 8, signed width of each complex component (re, im).
REQ-002 Parameter AW, default 5, register-file address width; depth 2**AW.
REQ-003 Parameter SAT, default 0; 0 = wrap-around arithmetic, 1 = saturate to signed DW range.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  instruction offered.
REQ-007 in_ready  out  1  core accepts instruction; equals ~stall.
REQ-008 in_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 LOAD immediate.
REQ-009 in_a1, in_a2  in  AW each  source operand addresses.
REQ-010 in_a3  in  AW  destination address.
REQ-011 in_imm  in  2*DW  LOAD value, packed {re, im}, re in upper DW bits.
REQ-012 stall  in  1  freeze whole pipeline.
REQ-013 wb_valid  out  1  writeback occurring at next rising edge.
REQ-014 wb_addr  out  AW, wb_data  out  2*DW  writeback destination and packed value.
REQ-015 retired  out  32  count of completed writebacks.
REQ-016 dbg_addr  in  AW, dbg_data  out  2*DW  combinational register-file read port.

Function
REQ-017 Complex values SHALL use the {re, im} packing, two's complement, in the register file and on all ports.
REQ-018 An instruction SHALL be accepted on a rising edge where in_valid & in_ready; the edge loads stage S1 (op, a1, a2, a3, imm, valid).
REQ-019 On each un-stalled edge: S2 SHALL capture op, a3, imm and operands for S1's a1/a2; S3 SHALL capture ALU(S2) result and a3; the register file SHALL write S3 data to S3 a3 when S3 valid.
REQ-020 Latency: instruction accepted at edge k SHALL drive wb_valid/wb_addr/wb_data from S3 during cycle k+2..k+3 and update the register file at edge k+3.
REQ-021 Operand forwarding priority SHALL be: S2 ALU output if S2 valid and S2 a3 matches; else S3 data if S3 valid and matches; else register file.
REQ-022 Back-to-back dependent instructions SHALL complete with no bubbles and correct values.
REQ-023 ADD/SUB SHALL operate componentwise; MUL SHALL compute re = ac - bd, im = ad + bc at full width before reduction.
REQ-024 Reduction to DW: SAT=0 keeps low DW bits; SAT=1 clamps to [-2**(DW-1), 2**(DW-1)-1].
REQ-025 LOAD SHALL write in_imm unchanged to a3; sources ignored.
REQ-026 While stall = 1: no acceptance, S1/S2/S3 hold, no register write, retired holds, wb_valid forced 0.
REQ-027 retired SHALL increment by 1 on each edge performing a register write, wrapping at 2**32.
REQ-028 A read of an address written on the same edge SHALL return the new value via forwarding; dbg_data SHALL reflect the register file only.

Reset
REQ-029 rst high SHALL immediately clear S1/S2/S3 valid bits, all register-file entries, and retired; wb_valid, wb_addr, wb_data SHALL read 0.
REQ-030 rst asserted mid-operation SHALL discard all in-flight instructions; none SHALL write back after release.
REQ-031 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 Pulse rst -> retired=0, wb_valid=0, dbg_data=0 for addresses 0, 7, 31.
REQ-033 LOAD r1=(3,4), LOAD r2=(1,-2), ADD r3=r1+r2 on consecutive cycles -> wb r3=(4,2) three edges after ADD accepted; retired=3.
REQ-034 Same loads, then MUL r4=r1*r2 immediately -> wb r4=(11,-2); SUB r5=r4-r1 next cycle -> (8,-6).
REQ-035 DW=8, r1=(100,-100), ADD r6=r1+r1 -> SAT=0 gives (-56,56); SAT=1 gives (127,-128).
REQ-036 stall high 2 cycles between dependent instructions -> in_ready=0, no writeback or retired change during stall, final values identical to un-stalled run.
REQ-037 rst pulsed one cycle after three instructions accepted -> no wb_valid afterwards; all registers read 0; retired=0.
